// File: rtl/hazard_stall_ctrl.sv
// Hazard detection and stall control for the five-stage pipeline: load-use stalls of
// configurable length, HI/LO scoreboard for the multi-cycle mult/div unit, branch flush.
`timescale 1ns/1ps
module hazard_stall_ctrl #(
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 1,
    parameter int MDU_LAT  = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [REG_W-1:0]                  id_rs,
    input  logic [REG_W-1:0]                  id_rt,
    input  logic                              id_uses_rs,
    input  logic                              id_uses_rt,
    input  logic                              id_mdu_start,
    input  logic                              id_reads_hilo,
    input  logic [1:0]                        ex_MemRead,
    input  logic [REG_W-1:0]                  ex_rt,
    input  logic                              branch_taken,
    output logic                              PCWrite,
    output logic                              If_Id_Write,
    output logic                              Stall,
    output logic                              If_Id_Flush,
    output logic                              mdu_busy,
    output logic [$clog2(LOAD_LAT+1)-1:0]     load_cnt
);

    localparam int LCW = $clog2(LOAD_LAT + 1);
    localparam int MCW = $clog2(MDU_LAT + 1);
    localparam logic [LCW-1:0]   L_ZERO    = LCW'(1'b0);
    localparam logic [LCW-1:0]   L_ONE     = LCW'(1'b1);
    localparam logic [LCW-1:0]   L_INIT    = LCW'(LOAD_LAT - 1);
    localparam logic [MCW-1:0]   M_ZERO    = MCW'(1'b0);
    localparam logic [MCW-1:0]   M_ONE     = MCW'(1'b1);
    localparam logic [MCW-1:0]   M_INIT    = MCW'(MDU_LAT);
    localparam logic [REG_W-1:0] REG_ZERO  = REG_W'(1'b0);

    logic [LCW-1:0] load_cnt_r;
    logic [LCW-1:0] load_nxt_s;
    logic [MCW-1:0] mdu_cnt_r;
    logic [MCW-1:0] mdu_nxt_s;
    logic           load_hit_s;
    logic           mdu_busy_s;
    logic           mdu_hit_s;
    logic           hold_s;

    // Hazard terms; register $0 is hard-wired and never creates a dependency.
    always_comb begin
        load_hit_s = (ex_MemRead != 2'b00) && (ex_rt != REG_ZERO) &&
                     ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));
        mdu_busy_s = (mdu_cnt_r != M_ZERO);
        mdu_hit_s  = mdu_busy_s && (id_reads_hilo || id_mdu_start);
        hold_s     = load_hit_s || (load_cnt_r != L_ZERO) || mdu_hit_s;
    end

    // Next-state for both counters; a branch cancels pending load stalls but not MDU work.
    always_comb begin
        load_nxt_s = load_cnt_r;
        mdu_nxt_s  = mdu_cnt_r;
        if (branch_taken) begin
            load_nxt_s = L_ZERO;
        end else if (load_hit_s && (load_cnt_r == L_ZERO)) begin
            load_nxt_s = L_INIT;
        end else if (load_cnt_r != L_ZERO) begin
            load_nxt_s = load_cnt_r - L_ONE;
        end else begin
            load_nxt_s = L_ZERO;
        end
        if (id_mdu_start && !hold_s && !branch_taken) begin
            mdu_nxt_s = M_INIT;
        end else if (mdu_cnt_r != M_ZERO) begin
            mdu_nxt_s = mdu_cnt_r - M_ONE;
        end else begin
            mdu_nxt_s = M_ZERO;
        end
    end

    // Counter state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_cnt_r <= L_ZERO;
            mdu_cnt_r  <= M_ZERO;
        end else begin
            load_cnt_r <= load_nxt_s;
            mdu_cnt_r  <= mdu_nxt_s;
        end
    end

    // Pipeline control outputs; reset holds the pipeline frozen with a bubble in ID/EX.
    always_comb begin
        PCWrite     = 1'b1;
        If_Id_Write = 1'b1;
        Stall       = 1'b0;
        If_Id_Flush = 1'b0;
        if (!rst) begin
            PCWrite     = 1'b0;
            If_Id_Write = 1'b0;
            Stall       = 1'b1;
            If_Id_Flush = 1'b0;
        end else if (branch_taken) begin
            PCWrite     = 1'b1;
            If_Id_Write = 1'b1;
            Stall       = 1'b1;
            If_Id_Flush = 1'b1;
        end else if (hold_s) begin
            PCWrite     = 1'b0;
            If_Id_Write = 1'b0;
            Stall       = 1'b1;
            If_Id_Flush = 1'b0;
        end else begin
            PCWrite     = 1'b1;
            If_Id_Write = 1'b1;
            Stall       = 1'b0;
            If_Id_Flush = 1'b0;
        end
    end

    assign mdu_busy = rst && mdu_busy_s;
    assign load_cnt = load_cnt_r;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: a vector table for single-cycle decisions plus
// hand sequences for multi-cycle stalls, branch priority, overlap and async reset.
`timescale 1ns/1ps
module tb_hazard_stall_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic       id_mdu_start;
    logic       id_reads_hilo;
    logic [1:0] ex_MemRead;
    logic [4:0] ex_rt;
    logic       branch_taken;

    logic       pc1, w1, s1, f1, b1;
    logic [0:0] lc1;
    logic       pc2, w2, s2, f2, b2;
    logic [1:0] lc2;
    logic       pc3, w3, s3, f3, b3;
    logic [1:0] lc3;

    int total = 0;
    int bad   = 0;

    hazard_stall_ctrl #(.REG_W(5), .LOAD_LAT(1), .MDU_LAT(4)) u1 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt), .id_mdu_start(id_mdu_start), .id_reads_hilo(id_reads_hilo),
        .ex_MemRead(ex_MemRead), .ex_rt(ex_rt), .branch_taken(branch_taken),
        .PCWrite(pc1), .If_Id_Write(w1), .Stall(s1), .If_Id_Flush(f1), .mdu_busy(b1), .load_cnt(lc1));

    hazard_stall_ctrl #(.REG_W(5), .LOAD_LAT(2), .MDU_LAT(6)) u2 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt), .id_mdu_start(id_mdu_start), .id_reads_hilo(id_reads_hilo),
        .ex_MemRead(ex_MemRead), .ex_rt(ex_rt), .branch_taken(branch_taken),
        .PCWrite(pc2), .If_Id_Write(w2), .Stall(s2), .If_Id_Flush(f2), .mdu_busy(b2), .load_cnt(lc2));

    hazard_stall_ctrl #(.REG_W(5), .LOAD_LAT(3), .MDU_LAT(5)) u3 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt), .id_mdu_start(id_mdu_start), .id_reads_hilo(id_reads_hilo),
        .ex_MemRead(ex_MemRead), .ex_rt(ex_rt), .branch_taken(branch_taken),
        .PCWrite(pc3), .If_Id_Write(w3), .Stall(s3), .If_Id_Flush(f3), .mdu_busy(b3), .load_cnt(lc3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       st;
        logic       hl;
        logic [1:0] mr;
        logic [4:0] ert;
        logic       br;
        logic       pc;
        logic       w;
        logic       s;
        logic       f;
        logic       busy;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drv(input logic [4:0] rs_v, input logic [4:0] rt_v, input logic urs_v,
                       input logic urt_v, input logic st_v, input logic hl_v,
                       input logic [1:0] mr_v, input logic [4:0] ert_v, input logic br_v);
        id_rs         = rs_v;
        id_rt         = rt_v;
        id_uses_rs    = urs_v;
        id_uses_rt    = urt_v;
        id_mdu_start  = st_v;
        id_reads_hilo = hl_v;
        ex_MemRead    = mr_v;
        ex_rt         = ert_v;
        branch_taken  = br_v;
    endtask

    task automatic idle();
        drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 1'b0);
    endtask

    // lw $2 in EX, ID reads $2 through rs
    task automatic lw_hit();
        drv(5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 5'd2, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        idle();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        tbl[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{5'd7, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{5'd1, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{5'd3, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{5'd4, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        // reset state
        #1;
        chk("rst_pc", pc1, 1'b0);
        chk("rst_w", w1, 1'b0);
        chk("rst_stall", s1, 1'b1);
        chk("rst_flush", f1, 1'b0);
        chk("rst_busy", b1, 1'b0);
        chk("rst_lcnt", lc3, 2'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post_rst_pc", pc1, 1'b1);
        chk("post_rst_stall", s1, 1'b0);

        // single-cycle decisions on the LOAD_LAT=1 instance
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drv(tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt, tbl[i].st, tbl[i].hl,
                tbl[i].mr, tbl[i].ert, tbl[i].br);
            #1;
            chk($sformatf("vec%0d_pc", i), pc1, tbl[i].pc);
            chk($sformatf("vec%0d_w", i), w1, tbl[i].w);
            chk($sformatf("vec%0d_stall", i), s1, tbl[i].s);
            chk($sformatf("vec%0d_flush", i), f1, tbl[i].f);
            chk($sformatf("vec%0d_busy", i), b1, tbl[i].busy);
            chk($sformatf("vec%0d_lcnt", i), lc1, 1'b0);
        end

        // load-use length for LOAD_LAT = 1, 2, 3; load leaves EX after one cycle
        do_reset();
        @(negedge clk);
        lw_hit();
        #1;
        chk("ld_c0_s1", s1, 1'b1);
        chk("ld_c0_s2", s2, 1'b1);
        chk("ld_c0_s3", s3, 1'b1);
        chk("ld_c0_pc3", pc3, 1'b0);
        chk("ld_c0_lc3", lc3, 2'd0);
        @(negedge clk);
        idle();
        #1;
        chk("ld_c1_s1", s1, 1'b0);
        chk("ld_c1_pc1", pc1, 1'b1);
        chk("ld_c1_s2", s2, 1'b1);
        chk("ld_c1_lc2", lc2, 2'd1);
        chk("ld_c1_s3", s3, 1'b1);
        chk("ld_c1_w3", w3, 1'b0);
        chk("ld_c1_lc3", lc3, 2'd2);
        @(negedge clk);
        #1;
        chk("ld_c2_s2", s2, 1'b0);
        chk("ld_c2_pc2", pc2, 1'b1);
        chk("ld_c2_lc2", lc2, 2'd0);
        chk("ld_c2_s3", s3, 1'b1);
        chk("ld_c2_lc3", lc3, 2'd1);
        @(negedge clk);
        #1;
        chk("ld_c3_s3", s3, 1'b0);
        chk("ld_c3_pc3", pc3, 1'b1);
        chk("ld_c3_w3", w3, 1'b1);
        chk("ld_c3_lc3", lc3, 2'd0);

        // mult accepted, then mflo waits MDU_LAT=4 cycles
        do_reset();
        @(negedge clk);
        drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 1'b0);
        #1;
        chk("mdu_acc_stall", s1, 1'b0);
        chk("mdu_acc_busy", b1, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd0, 1'b0);
            #1;
            chk($sformatf("mdu_c%0d_busy", c), b1, 1'b1);
            chk($sformatf("mdu_c%0d_stall", c), s1, 1'b1);
            chk($sformatf("mdu_c%0d_pc", c), pc1, 1'b0);
        end
        @(negedge clk);
        #1;
        chk("mdu_rel_busy", b1, 1'b0);
        chk("mdu_rel_stall", s1, 1'b0);
        chk("mdu_rel_pc", pc1, 1'b1);

        // branch overrides an active load stall (LOAD_LAT=3, load_cnt=2)
        do_reset();
        @(negedge clk);
        lw_hit();
        @(negedge clk);
        drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 1'b1);
        #1;
        chk("br_lc3", lc3, 2'd2);
        chk("br_flush", f3, 1'b1);
        chk("br_pc", pc3, 1'b1);
        chk("br_w", w3, 1'b1);
        chk("br_stall", s3, 1'b1);
        @(negedge clk);
        idle();
        #1;
        chk("br_after_lc3", lc3, 2'd0);
        chk("br_after_stall", s3, 1'b0);
        chk("br_after_flush", f3, 1'b0);
        @(negedge clk);
        drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 1'b1);
        #1;
        chk("br_mult_flush", f3, 1'b1);
        @(negedge clk);
        idle();
        #1;
        chk("br_mult_busy", b3, 1'b0);

        // load and MDU hazards overlapping on LOAD_LAT=2 / MDU_LAT=6
        do_reset();
        @(negedge clk);
        drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 1'b0);
        @(negedge clk);
        idle();
        #1;
        chk("ov_busy", b2, 1'b1);
        chk("ov_pre_stall", s2, 1'b0);
        @(negedge clk);
        drv(5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 5'd2, 1'b0);
        #1;
        chk("ov_c0_stall", s2, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            drv(5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 5'd0, 1'b0);
            #1;
            chk($sformatf("ov_c%0d_stall", c), s2, 1'b1);
            chk($sformatf("ov_c%0d_w", c), w2, 1'b0);
        end
        @(negedge clk);
        #1;
        chk("ov_rel_stall", s2, 1'b0);
        chk("ov_rel_pc", pc2, 1'b1);
        chk("ov_rel_busy", b2, 1'b0);
        chk("ov_rel_flush", f2, 1'b0);

        // asynchronous reset in the middle of an MDU busy period
        do_reset();
        @(negedge clk);
        drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 1'b0);
        @(negedge clk);
        idle();
        #1;
        chk("ar_busy_before", b1, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_busy", b1, 1'b0);
        chk("ar_stall", s1, 1'b1);
        chk("ar_pc", pc1, 1'b0);
        chk("ar_w", w1, 1'b0);
        chk("ar_flush", f1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ar_rel_pc", pc1, 1'b1);
        chk("ar_rel_stall", s1, 1'b0);
        chk("ar_rel_busy", b1, 1'b0);
        @(negedge clk);
        drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd0, 1'b0);
        #1;
        chk("ar_mflo_free", s1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Parametrised hazard detection and stall controller for the MIPS_R2000 five-stage pipeline. It replaces the single-cycle load-use hazard unit with one that supports:
- a configurable load-to-use latency;
- a multi-cycle mult/div unit (HI/LO scoreboard);
- taken-branch flush.

It sits beside the IF/ID and ID/EX pipeline registers and drives PCWrite, If_Id_Write and the ID/EX bubble mux select.

## Interface
Parameters:
- REG_W, 5: register-specifier width.
- LOAD_LAT, 1: bubble cycles required between a load in EX and a dependent instruction in ID; must be ≥1.
- MDU_LAT, 32: cycles the mult/div unit is busy after accepting an op; must be ≥1.

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- id_rs  in  REG_W  rs field of instruction in ID
- id_rt  in  REG_W  rt field of instruction in ID
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- id_mdu_start  in  1  ID instruction is mult/multu/div/divu
- id_reads_hilo  in  1  ID instruction is mfhi/mflo
- ex_MemRead  in  2  MemRead field of ID/EX; non-zero means the EX instruction is a load
- ex_rt  in  REG_W  load destination in EX
- branch_taken  in  1  branch resolved taken in EX this cycle
- PCWrite  out  1  PC update enable
- If_Id_Write  out  1  IF/ID register write enable
- Stall  out  1  forces zero controls into ID/EX (bubble)
- If_Id_Flush  out  1  clears IF/ID to nop
- mdu_busy  out  1  mult/div result not yet valid
- load_cnt  out  $clog2(LOAD_LAT+1)  remaining load-stall cycles (debug)

## Operation
State consists of two counters, both cleared on reset:
- load_cnt: load-stall cycles remaining.
- mdu_cnt: mult/div busy cycles remaining.

Outputs are combinational from the state and current inputs.

Hazard terms:
- load_hit = (ex_MemRead≠0) & (ex_rt≠0) & ((id_uses_rs & id_rs==ex_rt) | (id_uses_rt & id_rt==ex_rt)). Register $0 never hazards.
- mdu_busy = (mdu_cnt≠0).
- mdu_hit = mdu_busy & (id_reads_hilo | id_mdu_start).
- hold = load_hit | (load_cnt≠0) | mdu_hit.

Output priority, highest first:
1. branch_taken=1: If_Id_Flush=1, Stall=1, PCWrite=1, If_Id_Write=1. Branch wins over every stall. load_cnt is cleared to 0 on the next edge.
2. hold=1: PCWrite=0, If_Id_Write=0, Stall=1, If_Id_Flush=0.
3. Otherwise: PCWrite=1, If_Id_Write=1, Stall=0, If_Id_Flush=0.

Load counter, per edge (without branch):
- If load_hit & load_cnt==0, load LOAD_LAT-1.
- Else if load_cnt≠0, decrement.
- Result: exactly LOAD_LAT stall cycles per load-use. With LOAD_LAT=1 the counter stays 0 and behaviour matches the single-cycle unit.

MDU counter, per edge:
- If id_mdu_start & ~hold & ~branch_taken (op accepted into EX), load MDU_LAT.
- Else if mdu_cnt≠0, decrement.
- A flushed (branch) mdu op is not accepted.
- mdu_cnt is unaffected by branches once loaded.

A load hazard and an MDU hazard together stall until both clear. Neither counter wraps: decrement saturates at 0.

## Timing
- While rst=0, regardless of clock:
  - load_cnt=0 and mdu_cnt=0;
  - outputs forced to PCWrite=0, If_Id_Write=0, Stall=1, If_Id_Flush=0, mdu_busy=0.
- After rst rises with idle inputs: PCWrite=1, If_Id_Write=1, Stall=0.
- Load-use: Stall is asserted in the same cycle load_hit appears and stays high for LOAD_LAT consecutive cycles. PCWrite rises in the cycle after the last stall.
- MDU: mdu_busy rises the cycle after acceptance and stays high for exactly MDU_LAT cycles. A mfhi in ID is released in the first cycle mdu_busy=0.
- Reset asserted mid-stall aborts the stall immediately (asynchronous). No residual stall remains after release.
- Zero-cycle paths: inputs to outputs are combinational, and no output is registered.

## Test plan
- LOAD_LAT=1: lw $2 in EX (ex_MemRead=2'b01, ex_rt=2), ID reads rs=2 → Stall/PCWrite=0 for exactly 1 cycle, then normal.
- LOAD_LAT=3: same stimulus with the load leaving EX after one cycle → Stall high for 3 cycles, load_cnt sequence 2,1,0. ex_rt=0 with rs=0 → no stall.
- MDU_LAT=4: mult accepted, mflo in ID next cycle → mdu_busy high 4 cycles, mflo held those 4 cycles, released on the 5th.
- Branch priority: branch_taken=1 during an active load stall (load_cnt=2) → If_Id_Flush=1, PCWrite=1 that cycle, load_cnt=0 next cycle. A mult in ID under branch_taken is not accepted (mdu_busy stays 0).
- Overlap: load_hit and mdu_hit together with LOAD_LAT=2 and 5 MDU cycles remaining → stall lasts 5 cycles (the longer of the two).
- Reset: drop rst during an MDU busy period → mdu_busy=0 and Stall=1 immediately. After release with idle inputs → PCWrite=1, Stall=0.
